wrr2_txq_stage: RTL

- Two-channel descriptor buffering stage that sits directly upstream/downstream of the 2-way WRR arbiter in the TX scheduling path.
- Buffers per-tenant TX descriptors in two FIFOs and presents their non-empty status to the arbiter as requests.
- Consumes the arbiter's grants to pop the winning head into a single registered output port.
- Asserts back-pressure (gnt_busy) to the arbiter whenever the output register cannot accept a new descriptor.

---
 rtl/wrr2_txq_stage_pkg.sv | 13 +
 rtl/wrr2_txq_stage_sync_fifo.sv | 59 +++++
 rtl/wrr2_txq_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/wrr2_txq_stage_pkg.sv
// Shared definitions for the two-channel TX descriptor staging block.
package wrr2_txq_stage_pkg;

  // Default descriptor width in bits.
  localparam int DEFAULT_DW = 64;

  // Source channel identifier carried alongside each output descriptor.
  typedef logic [0:0] src_id_t;

  localparam src_id_t CH0 = 1'b0;
  localparam src_id_t CH1 = 1'b1;

endpackage

// File: rtl/wrr2_txq_stage_sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count and a head output
// read from the entry addressed by the registered read pointer.
module sync_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  // Full is judged on registered occupancy, so a full FIFO only accepts
  // again in the cycle after a pop has lowered the count.
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap modulo DEPTH naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wrr2_txq_stage.sv
// Two-channel descriptor buffer feeding a 2-way WRR arbiter: FIFO status
// becomes requests, grants pop the winning head into one output register.
module wrr2_txq_stage
  import wrr2_txq_stage_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [DW-1:0] in1_data,
  output logic          arb_req_val,
  output logic          arb_req0,
  output logic          arb_req1,
  output logic          arb_gnt_busy,
  input  logic          arb_gnt0,
  input  logic          arb_gnt1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  output logic [CW-1:0] occ0,
  output logic [CW-1:0] occ1,
  output logic          err_gnt
);

  logic [DW-1:0] head0;
  logic [DW-1:0] head1;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic          pop0;
  logic          pop1;
  logic          gnt_any;
  logic          gnt_bad;
  src_id_t       src_q;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (in0_valid),
    .push_data (in0_data),
    .pop       (pop0),
    .head      (head0),
    .full      (full0),
    .empty     (empty0),
    .count     (occ0)
  );

  sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (in1_valid),
    .push_data (in1_data),
    .pop       (pop1),
    .head      (head1),
    .full      (full1),
    .empty     (empty1),
    .count     (occ1)
  );

  // Requests come purely from registered FIFO state, never from in*_valid.
  assign in0_ready    = ~full0;
  assign in1_ready    = ~full1;
  assign arb_req0     = ~empty0;
  assign arb_req1     = ~empty1;
  assign arb_req_val  = arb_req0 | arb_req1;
  assign arb_gnt_busy = out_valid & ~out_ready;

  // A double grant resolves to channel 0; channel 1 is only popped when it
  // holds the sole grant.
  assign pop0    = arb_gnt0 & ~arb_gnt_busy & ~empty0;
  assign pop1    = arb_gnt1 & ~arb_gnt0 & ~arb_gnt_busy & ~empty1;
  assign gnt_any = arb_gnt0 | arb_gnt1;
  assign gnt_bad = (arb_gnt0 & arb_gnt1)
                 | (arb_gnt0 & empty0)
                 | (arb_gnt1 & empty1)
                 | (gnt_any & arb_gnt_busy);

  assign out_src = src_q[0];

  // Output register: load on a pop, drain on out_ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      src_q     <= CH0;
    end else if (pop0) begin
      out_valid <= 1'b1;
      out_data  <= head0;
      src_q     <= CH0;
    end else if (pop1) begin
      out_valid <= 1'b1;
      out_data  <= head1;
      src_q     <= CH1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flag for any grant the stage could not legally honour.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_gnt <= 1'b0;
    end else if (gnt_bad) begin
      err_gnt <= 1'b1;
    end
  end

endmodule
